// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: pop-side bus between the PS/2 receiver FIFO and its consumer.
//
// Handshake: 'ready' is high whenever the FIFO holds at least one byte and
// 'data' then shows the head byte. A byte is consumed on the rising clk edge
// where both 'ready' and 'read_next' are high; 'read_next' while 'ready' is low
// is ignored. 'overflow' is sticky until reset; 'frame_err' is a single-cycle
// pulse for a rejected frame.
interface ps2_rx_fifo_if;
    logic       read_next;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       frame_err;

    // Receiver side: produces bytes and status, consumes pop requests.
    modport master (
        input  read_next,
        output ready,
        output data,
        output overflow,
        output frame_err
    );

    // Consumer side: issues pop requests, observes bytes and status.
    modport slave (
        output read_next,
        input  ready,
        input  data,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver feeding a small byte FIFO.
//
// Raw ps2_clk/ps2_dat are synchronised into clk, 11-bit frames are
// deserialised on ps2_clk falling edges, and completed scan codes are queued
// for the downstream scan-code state machine. A partial frame is abandoned
// after TIMEOUT_CYC clk cycles without a ps2_clk fall.
//
// Optional feature macro: PS2_FRAME_CHECK_EN
//   defined   : frames need start=0, stop=1 and odd parity; bad frames are
//               dropped and pulse frame_err.
//   undefined : every completed frame is queued; frame_err is tied low.
//
// dbg_bit_cnt exposes the deserialiser position for observation.
module ps2_rx_fifo #(
    parameter int ADDR_W      = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_dat,
    ps2_rx_fifo_if.master bus,
    output logic [3:0]    dbg_bit_cnt
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    // ------------------------------------------------------------------
    // Synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic [2:0] cs;
    logic [1:0] ds;
    logic       ps2_fall;
    logic       ps2_bit;

    // Shift raw lines into clk; reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs <= 3'b111;
            ds <= 2'b11;
        end else begin
            cs <= {cs[1:0], ps2_clk};
            ds <= {ds[0], ps2_dat};
        end
    end

    // ds[1] has the same latency as cs[1], so it is the bit present at the fall.
    assign ps2_fall = cs[2] & ~cs[1];
    assign ps2_bit  = ds[1];

    // ------------------------------------------------------------------
    // Deserialiser with idle timeout
    // ------------------------------------------------------------------
    logic [3:0]        bit_cnt;
    logic [10:0]       shreg;
    logic [IDLE_W-1:0] idle_cnt;
    logic [10:0]       frame_next;
    logic              frame_done;
    logic              idle_expired;
    logic              frame_ok;

    // Bits arrive LSB first, so each new bit enters at the top. On the
    // eleventh fall frame_next holds the whole frame with start at [0].
    assign frame_next   = {ps2_bit, shreg[10:1]};
    assign frame_done   = ps2_fall && (bit_cnt == 4'd10);
    assign idle_expired = (bit_cnt != 4'd0) &&
                          (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    // Count bits per frame; a stalled partial frame is silently discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 4'd0;
            shreg    <= 11'd0;
            idle_cnt <= '0;
        end else if (ps2_fall) begin
            shreg    <= frame_next;
            idle_cnt <= '0;
            bit_cnt  <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end else if (idle_expired) begin
            bit_cnt  <= 4'd0;
            idle_cnt <= '0;
        end else if (bit_cnt != 4'd0) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign dbg_bit_cnt = bit_cnt;

    // shreg[0] is always shifted out before it could be read.
    logic unused_shreg_lsb;
    assign unused_shreg_lsb = shreg[0];

`ifdef PS2_FRAME_CHECK_EN
    logic frame_err_q;

    // Start low, stop high, and data plus parity carrying an odd count of ones.
    assign frame_ok = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

    // One-cycle pulse in the cycle after a rejected frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_done & ~frame_ok;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    // Framing bits are ignored entirely in this build.
    logic unused_frame_bits;
    assign unused_frame_bits = ^{frame_next[10:9], frame_next[0]};
    assign frame_ok          = 1'b1;
    assign bus.frame_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            do_drop;
    logic            overflow_q;

    // The extra pointer bit tells full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A pop in the completion cycle frees the slot the new byte needs.
    assign do_pop  = bus.read_next & ~empty;
    assign do_push = frame_done & frame_ok & (~full | do_pop);
    assign do_drop = frame_done & frame_ok & full & ~do_pop;

    // Storage; cleared on reset so data reads 0 while empty after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= frame_next[8:1];
        end
    end

    // Pointers wrap naturally over ADDR_W+1 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky record of any accepted byte lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (do_drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.ready    = ~empty;
    assign bus.data     = mem[rd_ptr[ADDR_W-1:0]];
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: self-checking bench for ps2_rx_fifo.
// The driver serialises PS/2 frames and predicts each outcome with a queue
// model of an 8-entry FIFO; the monitor pops bytes and compares them in order.
module tb_ps2_rx_fifo;

    localparam int ADDR_W      = 3;
    localparam int DEPTH       = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 8;

`ifdef PS2_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [3:0] dbg_bit_cnt;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .bus         (bus),
        .dbg_bit_cnt (dbg_bit_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_tests      = 0;
    int         n_fail       = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf      = 1'b0;
    int         exp_err_cnt  = 0;
    int         seen_err_cnt = 0;
    int         pop_mode     = 0;   // 0: force_pop, 1: random, 2: ready delayed
    bit         force_pop    = 1'b0;
    bit         prev_ready   = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    // On each falling clk edge choose read_next for the coming rising edge;
    // if that edge will pop, the head byte shown now is what leaves the FIFO.
    initial begin
        bus.read_next = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.read_next = 1'b0;
                prev_ready    = 1'b0;
            end else begin
                case (pop_mode)
                    1:       bus.read_next = ($urandom_range(0, 3) != 0);
                    2:       bus.read_next = prev_ready;
                    default: bus.read_next = force_pop;
                endcase
                if (bus.frame_err) seen_err_cnt++;
                if (bus.read_next && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got %0h expected no byte at %0t", bus.data, $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("pop_data", {24'd0, bus.data}, {24'd0, mon_exp});
                    end
                end
                prev_ready = bus.ready;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic v);
        @(negedge clk);
        ps2_dat = v;
        repeat (HALF - 1) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    // Send one frame. The model decides up front whether the byte is queued,
    // dropped (overflow) or rejected. sim_pop requests a pop in the completion
    // cycle; chk_lat checks exact output timing (FIFO must start empty).
    task automatic send_frame(input logic [7:0] b, input bit bad_start, input bit bad_par,
                              input bit bad_stop, input bit sim_pop, input bit chk_lat);
        logic [10:0] bits;
        bit          accept;
        bits   = {~bad_stop, (~(^b)) ^ bad_par, b, bad_start};
        accept = !CHECK_EN || (bits[0] == 1'b0 && bits[10] == 1'b1 && (^bits[9:1]) == 1'b1);
        if (accept) begin
            if (exp_q.size() < DEPTH || sim_pop) exp_q.push_back(b);
            else exp_ovf = 1'b1;
        end else begin
            exp_err_cnt++;
        end
        for (int i = 0; i < 10; i++) send_bit(bits[i]);
        @(negedge clk);
        ps2_dat = bits[10];
        repeat (HALF - 1) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 force_pop = sim_pop;
        @(negedge clk);
        if (chk_lat) check("lat_not_yet_ready", {31'd0, bus.ready}, 32'd0);
        @(posedge clk);
        #1 force_pop = 1'b0;
        @(negedge clk);
        if (chk_lat) begin
            check("lat_ready", {31'd0, bus.ready}, {31'd0, accept});
            if (accept) check("lat_data", {24'd0, bus.data}, {24'd0, b});
            check("frame_err_pulse", {31'd0, bus.frame_err}, {31'd0, !accept});
        end
        @(negedge clk);
        if (chk_lat) check("frame_err_end", {31'd0, bus.frame_err}, 32'd0);
        repeat (HALF - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic drain(input int mode);
        int guard;
        guard    = 0;
        pop_mode = mode;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
        pop_mode = 0;
        repeat (2) @(negedge clk);
        check("drain_ready_low", {31'd0, bus.ready}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_data", {24'd0, bus.data}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_bit_cnt", {28'd0, dbg_bit_cnt}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame with exact completion-to-ready latency.
        send_frame(8'h1C, 0, 0, 0, 0, 1);
        check("t1_overflow", {31'd0, bus.overflow}, 32'd0);
        drain(1);

        // Three frames queued, then popped with read_next = ready delayed.
        send_frame(8'h1C, 0, 0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0, 0, 0);
        drain(2);

        // Nine frames without pops: the ninth overflows.
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 0, 0, 0, 0, 0);
            if (i == 7) check("t3_no_ovf_at_8", {31'd0, bus.overflow}, 32'd0);
        end
        check("t3_ovf_after_9", {31'd0, bus.overflow}, {31'd0, exp_ovf});
        drain(2);
        check("t3_ovf_sticky", {31'd0, bus.overflow}, {31'd0, exp_ovf});

        // Full FIFO with the ninth frame completing alongside a pop.
        reset_dut();
        check("t4_ovf_cleared", {31'd0, bus.overflow}, 32'd0);
        for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 0, 0, 0);
        send_frame(8'hE7, 0, 0, 0, 1, 0);
        check("t4_no_ovf", {31'd0, bus.overflow}, {31'd0, exp_ovf});
        drain(2);

        // Inverted parity.
        send_frame(8'h1C, 0, 1, 0, 0, 1);
        drain(1);

        // Stalled partial frame is abandoned, then a clean frame follows.
        send_partial(5);
        check("t6_partial_cnt", {28'd0, dbg_bit_cnt}, 32'd5);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        check("t6_timeout_cnt", {28'd0, dbg_bit_cnt}, 32'd0);
        send_frame(8'h32, 0, 0, 0, 0, 1);
        drain(1);

        // Reset in the middle of a frame empties the FIFO.
        send_frame(8'hA5, 0, 0, 0, 0, 0);
        send_partial(4);
        check("t7_partial_cnt", {28'd0, dbg_bit_cnt}, 32'd4);
        reset_dut();
        check("t7_ready", {31'd0, bus.ready}, 32'd0);
        check("t7_bit_cnt", {28'd0, dbg_bit_cnt}, 32'd0);
        send_frame(8'h5A, 0, 0, 0, 0, 1);
        drain(1);

        // Random traffic with occasional framing faults and concurrent pops.
        pop_mode = 1;
        for (int i = 0; i < 30; i++) begin
            send_frame(8'($urandom_range(0, 255)),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 7) == 0), 0, 0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        drain(1);

        check("final_overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
        check("frame_err_count", seen_err_cnt, exp_err_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
